// File: rtl/cpu_mon_pkg.sv
// rtl/cpu_mon_pkg.sv - shared state encoding, exit syscall and saturating increment for the run monitor
package cpu_mon_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] SYSCALL_EXIT = 32'h0000_000C;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// rtl/pc_trace_buf.sv - ring of recent fetch PCs with saturating fill count and newest-relative read
module pc_trace_buf #(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 16,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [IDX_W:0]    count
);

  logic [ADDR_W-1:0] ring_q [DEPTH];
  logic [IDX_W-1:0]  wptr_q, wptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [IDX_W-1:0]  rd_ptr;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      count_d = '0;
    end else if (push) begin
      wptr_d = wptr_q + IDX_W'(1);
      if (count_q != (IDX_W+1)'(DEPTH))
        count_d = count_q + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Contents need no reset; only entries below count are meaningful.
  always_ff @(posedge clk) begin
    if (reset && !clear && push)
      ring_q[wptr_q] <= push_pc;
  end

  assign rd_ptr = wptr_q - IDX_W'(1) - rd_idx;
  assign rd_pc  = ring_q[rd_ptr];
  assign count  = count_q;

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - detects CPU program end or timeout, checks result values, traces fetch PCs
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int NUM_CHECKS  = 4,
  parameter  int MAX_CYCLES  = 20000,
  parameter  int HALT_STABLE = 4,
  parameter  int TRACE_DEPTH = 16,
  localparam int IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            pc,
  input  logic [DATA_W-1:0]            ir,
  input  logic                         instr_valid,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_expect,
  input  logic [IDX_W-1:0]             trace_rd_idx,
  output logic [ADDR_W-1:0]            trace_rd_pc,
  output logic [IDX_W:0]               trace_count,
  output logic [1:0]                   state,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [31:0]                  cycle_count,
  output logic [31:0]                  instr_count,
  output logic [NUM_CHECKS-1:0]        mismatch_mask
);

  localparam int STALL_W = $clog2(HALT_STABLE) + 1;

  logic [1:0]            state_q, state_d;
  logic                  done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [31:0]           cycle_q, cycle_d, instr_q, instr_d;
  logic [NUM_CHECKS-1:0] mask_q, mask_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic [ADDR_W-1:0]     prev_pc_q, prev_pc_d;
  logic                  halt, trace_clear, trace_push;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    mask_d      = mask_q;
    stall_d     = stall_q;
    prev_pc_d   = pc;
    halt        = 1'b0;
    trace_clear = 1'b0;
    trace_push  = 1'b0;
    case (state_q)
      ST_RUN: begin
        cycle_d = sat_inc(cycle_q);
        if (instr_valid) begin
          instr_d    = sat_inc(instr_q);
          trace_push = 1'b1;
        end
        stall_d = (pc == prev_pc_q) ? stall_q + STALL_W'(1) : '0;
        halt    = (instr_valid && ir == DATA_W'(SYSCALL_EXIT)) ||
                  (stall_d == STALL_W'(HALT_STABLE - 1));
        // Halt beats the cycle limit when both land in the same cycle.
        if (halt) begin
          state_d = ST_CHECK;
        end else if (cycle_q == 32'(MAX_CYCLES - 1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        for (int k = 0; k < NUM_CHECKS; k++)
          mask_d[k] = chk_data[k*DATA_W +: DATA_W] != chk_expect[k*DATA_W +: DATA_W];
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = (mask_d == '0);
      end
      default: begin
        if (start) begin
          state_d     = ST_RUN;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          cycle_d     = '0;
          instr_d     = '0;
          mask_d      = '0;
          stall_d     = '0;
          trace_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
      mask_q    <= '0;
      stall_q   <= '0;
      prev_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      mask_q    <= mask_d;
      stall_q   <= stall_d;
      prev_pc_q <= prev_pc_d;
    end
  end

  pc_trace_buf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .clear   (trace_clear),
    .push    (trace_push),
    .push_pc (pc),
    .rd_idx  (trace_rd_idx),
    .rd_pc   (trace_rd_pc),
    .count   (trace_count)
  );

  assign state         = state_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_q;
  assign instr_count   = instr_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - directed scoreboard bench for cpu_run_monitor
module tb_cpu_run_monitor;

  localparam int NC = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   pc = '0;
  logic [31:0]   ir = '0;
  logic          instr_valid = 1'b0;
  logic [127:0]  chk_data = '0;
  logic [127:0]  chk_expect = '0;
  logic [3:0]    trace_rd_idx = '0;
  logic [31:0]   trace_rd_pc;
  logic [4:0]    trace_count;
  logic [1:0]    state;
  logic          done, pass, timeout;
  logic [31:0]   cycle_count, instr_count;
  logic [3:0]    mismatch_mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  cpu_run_monitor #(
    .ADDR_W(32), .DATA_W(DW), .NUM_CHECKS(NC), .MAX_CYCLES(50),
    .HALT_STABLE(4), .TRACE_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .ir(ir),
    .instr_valid(instr_valid), .chk_data(chk_data), .chk_expect(chk_expect),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_count(trace_count),
    .state(state), .done(done), .pass(pass), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count), .mismatch_mask(mismatch_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string t, input logic [63:0] v);
    sb.push_back('{t, v});
  endtask

  function automatic logic [63:0] observe(input string t);
    case (t)
      "state":       return {62'b0, state};
      "done":        return {63'b0, done};
      "pass":        return {63'b0, pass};
      "timeout":     return {63'b0, timeout};
      "cycle_count": return {32'b0, cycle_count};
      "instr_count": return {32'b0, instr_count};
      "mask":        return {60'b0, mismatch_mask};
      "trace_count": return {59'b0, trace_count};
      "trace_pc":    return {32'b0, trace_rd_pc};
      default:       return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] o;
      e = sb.pop_front();
      o = observe(e.tag);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic check_now(input string t, input logic [63:0] v);
    exp_push(t, v);
    drain();
  endtask

  task automatic do_start(input logic [31:0] start_pc);
    pc          = start_pc;
    instr_valid = 1'b0;
    start       = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_run_end(input logic p, input logic to, input logic [31:0] cyc,
                                input logic [31:0] ins, input logic [3:0] m);
    exp_push("state", 64'd3);
    exp_push("done", 64'd1);
    exp_push("pass", {63'b0, p});
    exp_push("timeout", {63'b0, to});
    exp_push("cycle_count", {32'b0, cyc});
    exp_push("instr_count", {32'b0, ins});
    exp_push("mask", {60'b0, m});
  endtask

  initial begin
    chk_data   = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    chk_expect = chk_data;

    // 1: reset, then syscall on the 5th fetch
    step();
    step();
    reset = 1'b1;
    step();
    exp_push("state", 64'd0);
    exp_push("done", 64'd0);
    exp_push("pass", 64'd0);
    exp_push("timeout", 64'd0);
    exp_push("cycle_count", 64'd0);
    exp_push("instr_count", 64'd0);
    exp_push("mask", 64'd0);
    exp_push("trace_count", 64'd0);
    drain();

    do_start(32'h100);
    check_now("state", 64'd1);
    for (int i = 1; i <= 5; i++) begin
      pc          = 32'h100 + 32'(4 * i);
      ir          = (i == 5) ? 32'h0000_000C : 32'h0000_0013;
      instr_valid = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    ir          = '0;
    check_now("state", 64'd2);
    check_now("done", 64'd0);
    step();
    expect_run_end(1'b1, 1'b0, 32'd5, 32'd5, 4'b0000);
    exp_push("trace_count", 64'd5);
    trace_rd_idx = 4'd0;
    #1;
    exp_push("trace_pc", 64'h114);
    drain();

    // 2: pc stall at 0x40 with one mismatching check slot
    do_start(32'h3C);
    check_now("done", 64'd0);
    check_now("instr_count", 64'd0);
    pc = 32'h40;
    for (int i = 0; i < 3; i++) step();
    check_now("state", 64'd1);
    step();
    check_now("state", 64'd2);
    chk_data[2*DW +: DW] = 32'h1234_5678;
    step();
    expect_run_end(1'b0, 1'b0, 32'd4, 32'd0, 4'b0100);
    exp_push("trace_count", 64'd0);
    drain();
    chk_data = chk_expect;

    // 3: cycle limit, mismatching data must not show up in the mask
    chk_data[0 +: DW] = 32'h0;
    do_start(32'h1000);
    for (int i = 0; i < 49; i++) begin
      pc = 32'h2000 + 32'(4 * i);
      step();
    end
    check_now("state", 64'd1);
    check_now("done", 64'd0);
    pc = 32'h3000;
    step();
    expect_run_end(1'b0, 1'b1, 32'd50, 32'd0, 4'b0000);
    drain();
    chk_data = chk_expect;

    // 4: syscall on the same cycle as the limit
    do_start(32'h1000);
    for (int i = 0; i < 50; i++) begin
      pc          = 32'h2000 + 32'(4 * i);
      instr_valid = (i == 49);
      ir          = (i == 49) ? 32'h0000_000C : 32'h0;
      step();
    end
    instr_valid = 1'b0;
    ir          = '0;
    check_now("state", 64'd2);
    check_now("timeout", 64'd0);
    step();
    expect_run_end(1'b1, 1'b0, 32'd50, 32'd1, 4'b0000);
    drain();

    // 5: 20 fetches wrap the 16-entry ring, then stall to end the run
    do_start(32'hFFC);
    for (int i = 0; i < 20; i++) begin
      pc          = 32'(4 * i);
      ir          = 32'h13;
      instr_valid = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    exp_push("trace_count", 64'd16);
    trace_rd_idx = 4'd0;
    #1;
    exp_push("trace_pc", 64'h4C);
    drain();
    trace_rd_idx = 4'd15;
    #1;
    check_now("trace_pc", 64'h10);
    for (int i = 0; i < 3; i++) step();
    check_now("state", 64'd2);
    step();
    expect_run_end(1'b1, 1'b0, 32'd23, 32'd20, 4'b0000);
    drain();
    step();
    exp_push("trace_count", 64'd16);
    trace_rd_idx = 4'd1;
    #1;
    exp_push("trace_pc", 64'h48);
    drain();
    trace_rd_idx = 4'd15;
    #1;
    check_now("trace_pc", 64'h10);

    // 6: restart from DONE clears everything, then reset aborts mid-run
    do_start(32'h500);
    exp_push("state", 64'd1);
    exp_push("done", 64'd0);
    exp_push("pass", 64'd0);
    exp_push("cycle_count", 64'd0);
    exp_push("instr_count", 64'd0);
    exp_push("trace_count", 64'd0);
    drain();
    for (int i = 1; i <= 3; i++) begin
      pc          = 32'h500 + 32'(4 * i);
      instr_valid = 1'b1;
      step();
    end
    exp_push("cycle_count", 64'd3);
    exp_push("instr_count", 64'd3);
    exp_push("trace_count", 64'd3);
    drain();
    reset = 1'b0;
    step();
    reset       = 1'b1;
    instr_valid = 1'b0;
    exp_push("state", 64'd0);
    exp_push("done", 64'd0);
    exp_push("pass", 64'd0);
    exp_push("timeout", 64'd0);
    exp_push("cycle_count", 64'd0);
    exp_push("instr_count", 64'd0);
    exp_push("mask", 64'd0);
    exp_push("trace_count", 64'd0);
    drain();
    step();
    check_now("state", 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
